// File: rtl/fir_ibuff_sequencer.sv
// fir_ibuff_sequencer
// Reads FIR coefficients and then input samples from ibuff and streams them
// into fir_filter. Samples go out in sliding-window order (newest first) with
// zero padding at both ends of the series and an optional window stride of 2.
// A slot issued in cycle t shows up on fir_input in cycle t+1.

module fir_ibuff_sequencer #(
    parameter int INPUT_WIDTH      = 32,
    parameter int MAX_FILTER_SIZE  = 16,
    parameter int IBUFF_CELL_COUNT = 4096,
    localparam int FS_WIDTH        = $clog2(MAX_FILTER_SIZE),
    localparam int AW              = $clog2(IBUFF_CELL_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [FS_WIDTH-1:0]    filter_size,
    input  logic                   downsample,
    input  logic [AW-1:0]          coeff_base_addr,
    input  logic [AW-1:0]          data_base_addr,
    input  logic [AW:0]            series_length,
    output logic                   ibuff_r_en,
    output logic [AW-1:0]          ibuff_r_addr,
    input  logic [INPUT_WIDTH-1:0] ibuff_r_data,
    output logic                   init_filter,
    output logic                   input_valid,
    output logic [INPUT_WIDTH-1:0] fir_input,
    output logic                   busy,
    output logic                   done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_COEF  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    // Job parameters captured on start
    logic [2:0]          state_r;
    logic [FS_WIDTH-1:0] fs_r;
    logic                ds_r;
    logic [AW-1:0]       coef_base_r;
    logic [AW-1:0]       data_base_r;
    logic [AW:0]         len_r;
    logic [AW+1:0]       total_r;      // L+N-1: window bases run below this

    // Slot counters: they name the slot to be issued at the next edge
    logic [FS_WIDTH-1:0] k_r;          // coefficient index
    logic [AW+1:0]       b_r;          // window base
    logic [FS_WIDTH-1:0] i_r;          // slot within window

    // Issue stage (cycle t) and output stage (cycle t+1)
    logic                slot_r;
    logic                pad_r;
    logic                r_en_r;
    logic [AW-1:0]       addr_r;
    logic                valid_r;
    logic                opad_r;
    logic                init_r;
    logic                busy_r;
    logic                done_r;

    // Slot decode
    logic signed [AW+1:0] s_s;
    logic                 data_pad_s;
    logic [AW-1:0]        data_addr_s;
    logic [AW-1:0]        coef_addr_s;
    logic [AW+1:0]        b_first_s;
    logic [AW+1:0]        b_next_s;
    logic                 has_window_s;
    logic                 last_window_s;

    // Address and pad decode for the slot about to be issued
    always_comb begin
        s_s           = $signed(b_r) - $signed({{(AW+2-FS_WIDTH){1'b0}}, i_r});
        data_pad_s    = s_s[AW+1] || (s_s >= $signed({1'b0, len_r}));
        data_addr_s   = data_base_r + s_s[AW-1:0];
        coef_addr_s   = coef_base_r + {{(AW-FS_WIDTH){1'b0}}, k_r};
        b_first_s     = {{(AW+1){1'b0}}, ds_r};
        b_next_s      = b_r + (ds_r ? {{AW{1'b0}}, 2'd2} : {{(AW+1){1'b0}}, 1'b1});
        has_window_s  = (total_r > b_first_s);
        last_window_s = (b_next_s >= total_r);
    end

    // Sequencer FSM, read issue and output pipeline
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            fs_r        <= {FS_WIDTH{1'b0}};
            ds_r        <= 1'b0;
            coef_base_r <= {AW{1'b0}};
            data_base_r <= {AW{1'b0}};
            len_r       <= {(AW+1){1'b0}};
            total_r     <= {(AW+2){1'b0}};
            k_r         <= {FS_WIDTH{1'b0}};
            b_r         <= {(AW+2){1'b0}};
            i_r         <= {FS_WIDTH{1'b0}};
            slot_r      <= 1'b0;
            pad_r       <= 1'b0;
            r_en_r      <= 1'b0;
            addr_r      <= {AW{1'b0}};
            valid_r     <= 1'b0;
            opad_r      <= 1'b0;
            init_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            slot_r  <= 1'b0;
            pad_r   <= 1'b0;
            r_en_r  <= 1'b0;
            addr_r  <= {AW{1'b0}};
            init_r  <= 1'b0;
            done_r  <= 1'b0;
            valid_r <= slot_r;
            opad_r  <= pad_r;
            if ((state_r != ST_IDLE) && abort) begin
                // Drop everything, including the read already in flight
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
                valid_r <= 1'b0;
                opad_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            fs_r        <= filter_size;
                            ds_r        <= downsample;
                            coef_base_r <= coeff_base_addr;
                            data_base_r <= data_base_addr;
                            len_r       <= series_length;
                            total_r     <= {1'b0, series_length}
                                           + {{(AW+2-FS_WIDTH){1'b0}}, filter_size};
                            k_r         <= {FS_WIDTH{1'b0}};
                            b_r         <= {(AW+2){1'b0}};
                            i_r         <= {FS_WIDTH{1'b0}};
                            init_r      <= 1'b1;
                            busy_r      <= 1'b1;
                            state_r     <= ST_INIT;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_INIT, ST_COEF: begin
                        slot_r <= 1'b1;
                        r_en_r <= 1'b1;
                        addr_r <= coef_addr_s;
                        if (k_r == fs_r) begin
                            b_r     <= b_first_s;
                            i_r     <= {FS_WIDTH{1'b0}};
                            state_r <= has_window_s ? ST_DATA : ST_DRAIN;
                        end else begin
                            k_r     <= k_r + {{(FS_WIDTH-1){1'b0}}, 1'b1};
                            state_r <= ST_COEF;
                        end
                    end
                    ST_DATA: begin
                        slot_r <= 1'b1;
                        pad_r  <= data_pad_s;
                        r_en_r <= !data_pad_s;
                        addr_r <= data_pad_s ? {AW{1'b0}} : data_addr_s;
                        if (i_r == fs_r) begin
                            i_r <= {FS_WIDTH{1'b0}};
                            if (last_window_s) begin
                                state_r <= ST_DRAIN;
                            end else begin
                                b_r     <= b_next_s;
                                state_r <= ST_DATA;
                            end
                        end else begin
                            i_r     <= i_r + {{(FS_WIDTH-1){1'b0}}, 1'b1};
                            state_r <= ST_DATA;
                        end
                    end
                    ST_DRAIN: begin
                        // Last slot is on fir_input this cycle; finish next
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ibuff_r_en   = r_en_r;
    assign ibuff_r_addr = addr_r;
    assign init_filter  = init_r;
    assign input_valid  = valid_r;
    // ibuff data arrives one cycle after the read, so it is muxed straight through
    assign fir_input    = (valid_r && !opad_r) ? ibuff_r_data : {INPUT_WIDTH{1'b0}};
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_fir_ibuff_sequencer.sv
// Directed bench for fir_ibuff_sequencer with a behavioural ibuff model.
module tb_fir_ibuff_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [3:0]  filter_size;
    logic        downsample;
    logic [11:0] coeff_base_addr;
    logic [11:0] data_base_addr;
    logic [12:0] series_length;
    logic        ibuff_r_en;
    logic [11:0] ibuff_r_addr;
    logic [31:0] ibuff_r_data = 32'd0;
    logic        init_filter;
    logic        input_valid;
    logic [31:0] fir_input;
    logic        busy;
    logic        done;

    fir_ibuff_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .filter_size(filter_size), .downsample(downsample),
        .coeff_base_addr(coeff_base_addr), .data_base_addr(data_base_addr),
        .series_length(series_length), .ibuff_r_en(ibuff_r_en),
        .ibuff_r_addr(ibuff_r_addr), .ibuff_r_data(ibuff_r_data),
        .init_filter(init_filter), .input_valid(input_valid),
        .fir_input(fir_input), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];

    // ibuff: read data valid the cycle after r_en
    always @(posedge clk) begin
        if (ibuff_r_en) ibuff_r_data <= mem[ibuff_r_addr];
    end

    logic [31:0] out_q[$];
    logic [11:0] addr_q[$];
    logic [31:0] exp_q[$];
    logic [11:0] exp_a[$];
    int init_cnt, done_cnt, overlap_cnt;
    int checks = 0;
    int errors = 0;

    // Output monitor
    always @(negedge clk) begin
        if (input_valid) out_q.push_back(fir_input);
        if (ibuff_r_en) addr_q.push_back(ibuff_r_addr);
        if (init_filter) init_cnt++;
        if (done) done_cnt++;
        if (init_filter && input_valid) overlap_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_exp(input int fs, input int ds, input logic [11:0] cb,
                             input logic [11:0] db, input int len);
        int n, t, s;
        logic [11:0] a;
        exp_q.delete(); exp_a.delete();
        n = fs + 1;
        t = len + n - 1;
        for (int k = 0; k < n; k++) begin
            a = cb + k[11:0];
            exp_q.push_back(mem[a]); exp_a.push_back(a);
        end
        for (int b = ds; b < t; b += (ds != 0) ? 2 : 1) begin
            for (int i = 0; i < n; i++) begin
                s = b - i;
                if (s >= 0 && s < len) begin
                    a = db + s[11:0];
                    exp_q.push_back(mem[a]); exp_a.push_back(a);
                end else begin
                    exp_q.push_back(32'd0);
                end
            end
        end
    endtask

    task automatic launch(input int fs, input int ds, input logic [11:0] cb,
                          input logic [11:0] db, input int len);
        out_q.delete(); addr_q.delete();
        init_cnt = 0; done_cnt = 0; overlap_cnt = 0;
        build_exp(fs, ds, cb, db, len);
        filter_size = fs[3:0]; downsample = ds[0];
        coeff_base_addr = cb; data_base_addr = db; series_length = len[12:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_init_cnt"}, init_cnt, 1);
        chk({tag, "_overlap"}, overlap_cnt, 0);
        @(posedge clk); #1;
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_out_count"}, out_q.size(), exp_q.size());
        for (int j = 0; j < out_q.size() && j < exp_q.size(); j++)
            chk($sformatf("%s_out%0d", tag, j), out_q[j], exp_q[j]);
        chk({tag, "_rd_count"}, addr_q.size(), exp_a.size());
        for (int j = 0; j < addr_q.size() && j < exp_a.size(); j++)
            chk($sformatf("%s_addr%0d", tag, j), addr_q[j], exp_a[j]);
    endtask

    initial begin
        int idx;
        logic [11:0] a;
        for (int m = 0; m < 4096; m++) mem[m] = {20'hC0FFE, m[11:0]};
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        filter_size = 4'd0; downsample = 1'b0;
        coeff_base_addr = 12'd0; data_base_addr = 12'd0; series_length = 13'd0;
        #12;
        chk("reset_busy", busy, 1'b0);
        chk("reset_r_en", ibuff_r_en, 1'b0);
        chk("reset_addr", ibuff_r_addr, 12'd0);
        chk("reset_valid", input_valid, 1'b0);
        chk("reset_done", done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: N=4, L=8, no downsampling, plus latency
        launch(3, 0, 12'd200, 12'd1000, 8);
        @(negedge clk);
        chk("t1_init", init_filter, 1'b1);
        chk("t1_busy", busy, 1'b1);
        chk("t1_r_en_early", ibuff_r_en, 1'b0);
        @(negedge clk);
        chk("t1_init_off", init_filter, 1'b0);
        chk("t1_first_r_en", ibuff_r_en, 1'b1);
        chk("t1_first_addr", ibuff_r_addr, 12'd200);
        chk("t1_valid_early", input_valid, 1'b0);
        @(negedge clk);
        chk("t1_first_valid", input_valid, 1'b1);
        chk("t1_first_coef", fir_input, mem[200]);
        wait_done("t1");
        chk("t1_total", out_q.size(), 48);
        if (out_q.size() == 48) begin
            chk("t1_w0_s0", out_q[4], mem[1000]);
            chk("t1_w0_s1", out_q[5], 32'd0);
            chk("t1_w0_s3", out_q[7], 32'd0);
            chk("t1_wl_s0", out_q[44], 32'd0);
            chk("t1_wl_s3", out_q[47], mem[1007]);
        end
        cmp_stream("t1");

        // 2: same with x2 downsampling: b=1,3,5,7,9 -> 5 windows of 4
        launch(3, 1, 12'd200, 12'd1000, 8);
        wait_done("t2");
        chk("t2_total", out_q.size(), 24);
        if (out_q.size() == 24) begin
            chk("t2_w1_s0", out_q[4], mem[1001]);
            chk("t2_w1_s1", out_q[5], mem[1000]);
            chk("t2_w1_s2", out_q[6], 32'd0);
        end
        cmp_stream("t2");

        // 3: single tap, single sample
        launch(0, 0, 12'd7, 12'd50, 1);
        wait_done("t3");
        chk("t3_total", out_q.size(), 2);
        if (out_q.size() == 2) begin
            chk("t3_coef", out_q[0], mem[7]);
            chk("t3_data", out_q[1], mem[50]);
        end
        cmp_stream("t3");

        // 4: sample addresses wrap past the top of ibuff
        launch(1, 0, 12'd100, 12'd4094, 4);
        wait_done("t4");
        if (addr_q.size() > 2) chk("t4_first_data_addr", addr_q[2], 12'd4094);
        if (out_q.size() > 2) chk("t4_first_data", out_q[2], mem[4094]);
        cmp_stream("t4");

        // 5: abort mid-window in DATA, then a clean rerun
        launch(3, 0, 12'd200, 12'd1000, 8);
        idx = 0;
        while (out_q.size() < 10 && idx < 200) begin
            @(posedge clk); #1;
            idx++;
        end
        chk("t5_reached_data", out_q.size() >= 10, 1'b1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("t5_valid_off", input_valid, 1'b0);
        chk("t5_r_en_off", ibuff_r_en, 1'b0);
        chk("t5_busy_off", busy, 1'b0);
        repeat (5) @(negedge clk);
        chk("t5_no_done", done_cnt, 0);
        @(posedge clk); #1;
        launch(3, 0, 12'd200, 12'd1000, 8);
        wait_done("t5b");
        cmp_stream("t5b");

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("sa_busy", busy, 1'b0);
        chk("sa_init", init_filter, 1'b0);
        @(posedge clk); #1;

        // 6: asynchronous reset in COEF, then start while busy is ignored
        launch(3, 0, 12'd300, 12'd2000, 6);
        @(negedge clk); @(negedge clk); @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_r_en", ibuff_r_en, 1'b0);
        chk("t6_rst_valid", input_valid, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_addr", ibuff_r_addr, 12'd0);
        chk("t6_rst_fir", fir_input, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        launch(3, 0, 12'd300, 12'd2000, 6);
        repeat (6) @(posedge clk);
        #1;
        filter_size = 4'd0; data_base_addr = 12'd5; series_length = 13'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t6");
        chk("t6_total", out_q.size(), 4 + 4 * 9);
        cmp_stream("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
